// File: rtl/elastic_buffer_pkg.sv
// Shared constants, occupancy encoding and sizing helpers for elastic_buffer.
package elastic_buffer_pkg;

  localparam int EB_DEFAULT_N     = 16;
  localparam int EB_DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Width needed to hold every occupancy value 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic occ_e classify(input int cnt, input int depth);
    if (cnt == 0)     return OCC_EMPTY;
    if (cnt >= depth) return OCC_FULL;
    return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/elastic_buffer_mem.sv
// DEPTH x N register array: one synchronous write port, one asynchronous read port.
module elastic_buffer_mem #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // NOTE: storage has no reset; the pointers and count decide what is valid,
  // so clearing the array would only cost a reset fan-out to every bit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/elastic_buffer.sv
// First-word-fall-through elastic buffer. Define ELASTIC_BUFFER_PIPE_READY_EN
// to let a full buffer accept a word in the same cycle one is drained.
module elastic_buffer
  import elastic_buffer_pkg::*;
#(
  parameter int N     = EB_DEFAULT_N,
  parameter int DEPTH = EB_DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0]                  data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0]                  data_out,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [N-1:0]  rd_data;
  logic          push;
  logic          pop;
  occ_e          occ;

  // NOTE: every output of this block is assigned up front so no path leaves
  // a signal holding its old value, which would infer a latch.
  always_comb begin
    occ       = classify(int'(count), DEPTH);
    out_valid = (occ != OCC_EMPTY);
`ifdef ELASTIC_BUFFER_PIPE_READY_EN
    in_ready  = (occ != OCC_FULL) || out_ready;
`else
    in_ready  = (occ != OCC_FULL);
`endif
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
    data_out  = out_valid ? rd_data : '0;
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values,
  // so pointer and count updates below never see each other's new state.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so natural overflow wraps DEPTH-1 to 0.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  elastic_buffer_mem #(
    .N    (N),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer: directed stimulus queues expected words,
// a negedge monitor pops and compares every output handshake.
module tb_elastic_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  elastic_buffer #(.N(16), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d, input bit track);
    in_valid = 1'b1;
    data_in  = d;
    step();
    in_valid = 1'b0;
    if (track) exp_q.push_back(d);
  endtask

  // Monitor: every output handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got %0h expected none", data_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          miscompares++;
          $display("FAIL data_out: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; data_in = 16'hDEAD; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("reset_count",     count,     0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready",  in_ready,  1);
    check("reset_data_out",  data_out,  16'h0000);

    // Ordering
    push_word(16'h0E20, 1);
    push_word(16'h0B21, 1);
    push_word(16'h2388, 1);
    check("order_count", count, 3);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    check("order_empty_valid", out_valid, 0);
    check("order_empty_data",  data_out,  16'h0000);
    check("order_empty_count", count,     0);

    // Full: fifth word must be refused
    for (int i = 1; i <= 4; i++) push_word(16'(i), 1);
    check("full_in_ready", in_ready, 0);
    check("full_count",    count,    4);
    push_word(16'h0005, 0);
    check("full_count_after_5th", count, 4);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    check("full_drained", count, 0);

    // Wrap with simultaneous push/pop at count=2
    push_word(16'h00A0, 1);
    push_word(16'h00A1, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_word(16'h0100 + 16'(i), 1);
      check("wrap_count", count, 2);
    end
    repeat (2) step();
    out_ready = 1'b0;
    check("wrap_drained", count, 0);

    // Flush discards stored words and the same-cycle push
    push_word(16'h00C1, 0);
    push_word(16'h00C2, 0);
    push_word(16'h00C3, 0);
    check("pre_flush_count", count, 3);
    flush = 1'b1;
    push_word(16'hBEEF, 0);
    flush = 1'b0;
    check("flush_count",     count,     0);
    check("flush_out_valid", out_valid, 0);
    check("flush_data_out",  data_out,  16'h0000);
    push_word(16'h1234, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_flush_count", count, 0);

    // Full with out_ready=1 and a pending word
    for (int i = 0; i < 4; i++) push_word(16'h00D0 + 16'(i), 1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data_in   = 16'h2388;
    #1;
`ifdef ELASTIC_BUFFER_PIPE_READY_EN
    check("pipe_in_ready", in_ready, 1);
    step();
    exp_q.push_back(16'h2388);
    in_valid = 1'b0;
    check("pipe_count", count, 4);
    repeat (4) step();
`else
    check("pipe_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    check("pipe_count", count, 3);
    repeat (3) step();
`endif
    out_ready = 1'b0;
    check("pipe_drained", count, 0);

    // Reset mid-operation loses stored words
    push_word(16'h00E1, 0);
    push_word(16'h00E2, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_count", count, 0);
    push_word(16'h5555, 1);
    check("midreset_push_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elastic_buffer.md
ELASTIC_BUFFER -- requirements
Module: elastic_buffer

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits (N >= 1).
REQ-002 SHALL have parameter DEPTH, default 4, entry count (power of two, DEPTH >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all stored entries.
REQ-006 SHALL have port in_valid  input  1  producer offers data_in.
REQ-007 SHALL have port in_ready  output  1  buffer accepts data_in this cycle.
REQ-008 SHALL have port data_in  input  N  write data.
REQ-009 SHALL have port out_valid  output  1  data_out holds oldest entry.
REQ-010 SHALL have port out_ready  input  1  consumer takes data_out this cycle.
REQ-011 SHALL have port data_out  output  N  oldest stored entry, first-word-fall-through.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 SHALL push when in_valid && in_ready at a rising edge; pop when out_valid && out_ready.
REQ-014 SHALL track occupancy states EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH), derived from count.
REQ-015 SHALL drive out_valid = (count != 0) and in_ready = (count != DEPTH), both combinational from registered state only.
REQ-016 SHALL make a pushed word visible on data_out with out_valid=1 in the cycle after the push edge (latency 1, no combinational in-to-out path).
REQ-017 SHALL drive data_out = 0 whenever out_valid = 0.
REQ-018 SHALL preserve FIFO order; write/read pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 SHALL, on simultaneous push and pop in PARTIAL, keep count unchanged and advance both pointers.
REQ-020 SHALL ignore in_valid when FULL (no overwrite) and out_ready when EMPTY (no underflow, count stays 0).
REQ-021 SHALL, when flush=1 at an edge, set count and pointers to 0 and discard any same-cycle push and pop.
REQ-022 SHALL not hold data_in/in_valid stability requirements beyond the sampling edge.

Reset
REQ-023 SHALL, with rst=1 at an edge, set count=0, pointers=0; outputs then out_valid=0, in_ready=1, data_out=0, count=0.
REQ-024 SHALL give rst priority over flush, push and pop; storage array contents need not be reset.
REQ-025 SHALL, on reset mid-operation, lose all stored entries; first push after reset lands at entry 0.

Configuration
REQ-026 SHALL support macro ELASTIC_BUFFER_PIPE_READY_EN.
REQ-027 With macro defined: in_ready = (count != DEPTH) || out_ready; push and pop in same FULL cycle SHALL both occur, count stays DEPTH.
REQ-028 Without macro: in_ready exactly per REQ-015; no push in FULL regardless of out_ready.

Structure
REQ-029 SHALL place EB_DEFAULT_N (16), EB_DEFAULT_DEPTH (4) and a count-width helper function in package elastic_buffer_pkg.
REQ-030 SHALL isolate storage in sub-module elastic_buffer_mem (DEPTH x N register array, one write port, one async read port); pointer/count control stays in elastic_buffer.

Verification
REQ-031 Reset: rst=1 two cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1, data_out=16'h0000.
REQ-032 Ordering: push 16'h0E20, 16'h0B21, 16'h2388 on consecutive edges, out_ready=0 -> count=3; then out_ready=1 -> data_out 0E20, 0B21, 2388 on successive cycles, then out_valid=0.
REQ-033 Full: DEPTH=4, push 5 words 16'h0001..16'h0005 with out_ready=0 -> in_ready=0 after 4th, count=4, 16'h0005 never stored; drain yields 0001..0004.
REQ-034 Wrap/simultaneous: hold count=2, run 10 cycles in_valid=out_ready=1 with incrementing data -> count stays 2, output sequence gap-free and in order across pointer wrap.
REQ-035 Flush: count=3, assert flush with in_valid=1, data_in=16'hBEEF -> next cycle count=0, out_valid=0, 16'hBEEF not stored.
REQ-036 Macro: with ELASTIC_BUFFER_PIPE_READY_EN, FULL and out_ready=1, in_valid=1, data_in=16'h2388 -> in_ready=1, count stays 4, 16'h2388 emerges last; without macro in_ready=0 and word not accepted.
